// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/acknowledge bus
//
// Purpose: groups the fetch-side handshake to instruction memory.
// Signals:
//   imem_req    fetch request, held until acknowledged
//   imem_addr   fetch address (word aligned)
//   imem_ack    memory returns imem_rdata this cycle
//   imem_rdata  instruction word, valid with imem_ack
// Modports:
//   master  fetch stage (drives req/addr)
//   slave   instruction memory (drives ack/rdata)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage
//
// Purpose: holds the PC, fetches instruction words over a variable-latency
// request/acknowledge bus, presents a stable instruction to decode and
// computes the next PC when the core retires the current instruction.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          instruction memory bus (master side)
//   instr        registered instruction word
//   instr_valid  instr/pc describe a fetched, not-yet-retired instruction
//   pc           address of the current instruction
//   pc_plus4     pc + 4 (combinational, wraps)
//   instr_done   core finished instr; PCSrc/imm_ext valid this cycle
//   PCSrc        1 = branch target, 0 = sequential
//   imm_ext      sign-extended branch offset
//   fetch_fault  sticky misaligned-target fault
//   retire_cnt   number of retired instructions (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  input  logic          instr_done,
  input  logic          PCSrc,
  input  logic [31:0]   imm_ext,
  output logic          fetch_fault,
  output logic [31:0]   retire_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_next;
  logic [31:0] next_pc;
  logic        capture;
  logic        retire;
  logic        fault_set;

  assign pc_plus4 = pc + 32'd4;
  assign next_pc  = PCSrc ? (pc + imm_ext) : pc_plus4;

  // Handshake outputs are pure decodes of state, so an asynchronous reset
  // drops the request in the same instant it resets the state register.
  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = pc;
  assign instr_valid   = (state == VALID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    retire     = 1'b0;
    fault_set  = 1'b0;
    case (state)
      BOOT: begin
        state_next = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (instr_done) begin
          // Only a word-aligned target is legal; otherwise stop fetching
          // and leave pc pointing at the instruction that faulted.
          if (next_pc[1:0] == 2'b00) begin
            retire     = 1'b1;
            state_next = REQ;
          end else begin
            fault_set  = 1'b1;
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= NOP;
      fetch_fault <= 1'b0;
      retire_cnt  <= 32'd0;
    end else begin
      if (capture) begin
        instr <= bus.imem_rdata;
      end
      if (retire) begin
        pc         <= next_pc;
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_done;
  logic        PCSrc;
  logic [31:0] imm_ext;
  logic        fetch_fault;
  logic [31:0] retire_cnt;

  int total;
  int bad;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_done  (instr_done),
    .PCSrc       (PCSrc),
    .imm_ext     (imm_ext),
    .fetch_fault (fetch_fault),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, want);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample state while in REQ with immediate ack: captures data, moves to VALID.
  task automatic fetch(input logic [31:0] data);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic retire_with(input logic src, input logic [31:0] imm);
    instr_done = 1'b1;
    PCSrc      = src;
    imm_ext    = imm;
    step();
    instr_done = 1'b0;
    PCSrc      = 1'b0;
    imm_ext    = 32'd0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    instr_done     = 1'b0;
    PCSrc          = 1'b0;
    imm_ext        = 32'd0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;

    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h4);

    // Release with ack tied high: BOOT one cycle, REQ one cycle, then VALID.
    rst = 1'b0;
    step();
    chk("boot_req", {31'd0, bus.imem_req}, 32'd1);
    chk("boot_addr", bus.imem_addr, 32'h0);
    chk("boot_instr_held", instr, 32'h0000_0013);
    step();
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", pc, 32'h0);
    chk("first_req_low", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b0;

    // Spurious ack in VALID with new data.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack   = 1'b0;
    chk("spur_ack_instr", instr, 32'h0050_0093);
    chk("spur_ack_valid", {31'd0, instr_valid}, 32'd1);

    // Branch to 0x10.
    retire_with(1'b1, 32'h10);
    chk("br10_pc", pc, 32'h10);
    chk("br10_retire", retire_cnt, 32'd1);
    chk("br10_valid", {31'd0, instr_valid}, 32'd0);
    chk("br10_req", {31'd0, bus.imem_req}, 32'd1);

    // Spurious instr_done in REQ.
    instr_done = 1'b1;
    PCSrc      = 1'b1;
    imm_ext    = 32'h100;
    step();
    instr_done = 1'b0;
    PCSrc      = 1'b0;
    imm_ext    = 32'd0;
    chk("spur_done_pc", pc, 32'h10);
    chk("spur_done_retire", retire_cnt, 32'd1);

    // Wait states: request and address held, instr not captured.
    bus.imem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait_req%0d", i), {31'd0, bus.imem_req}, 32'd1);
      chk($sformatf("wait_addr%0d", i), bus.imem_addr, 32'h10);
      chk($sformatf("wait_instr%0d", i), instr, 32'h0050_0093);
      step();
    end
    chk("wait_req3", {31'd0, bus.imem_req}, 32'd1);
    fetch(32'h00A0_0113);
    chk("wait_capture", instr, 32'h00A0_0113);
    chk("wait_valid", {31'd0, instr_valid}, 32'd1);

    // Sequential 0x10 -> 0x14.
    retire_with(1'b0, 32'h0);
    chk("seq_addr", bus.imem_addr, 32'h14);
    chk("seq_retire", retire_cnt, 32'd2);
    fetch(32'h0000_0033);

    // Backward branch 0x14 + -8 -> 0x0C.
    retire_with(1'b1, 32'hFFFF_FFF8);
    chk("bwd_addr", bus.imem_addr, 32'h0C);
    chk("bwd_retire", retire_cnt, 32'd3);
    fetch(32'h0000_0013);

    // 0x0C + 0x14 -> 0x20.
    retire_with(1'b1, 32'h14);
    chk("to20_pc", pc, 32'h20);
    fetch(32'h0000_0063);

    // Misaligned target 0x20 + 6.
    retire_with(1'b1, 32'h6);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_pc", pc, 32'h20);
    chk("mis_retire", retire_cnt, 32'd4);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 10; i++) begin
      instr_done = ~instr_done;
      PCSrc      = 1'b0;
      step();
      chk($sformatf("flt_req%0d", i), {31'd0, bus.imem_req}, 32'd0);
      chk($sformatf("flt_pc%0d", i), pc, 32'h20);
    end
    instr_done   = 1'b0;
    bus.imem_ack = 1'b0;
    chk("flt_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("flt_instr", instr, 32'h0000_0063);
    chk("flt_retire", retire_cnt, 32'd4);

    // Clear fault via reset and get into REQ.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst2_req", {31'd0, bus.imem_req}, 32'd1);
    step();

    // Reset asserted mid-REQ together with an ack.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h7777_7777;
    rst            = 1'b1;
    #1;
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_instr", instr, 32'h0000_0013);
    chk("midrst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("midrst_retire", retire_cnt, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_boot_instr", instr, 32'h0000_0013);
    chk("post_req", {31'd0, bus.imem_req}, 32'd1);
    chk("post_addr", bus.imem_addr, 32'h0);
    step();
    bus.imem_ack = 1'b0;
    chk("post_instr", instr, 32'h7777_7777);

    // PC wrap: 0 + -4 -> 0xFFFFFFFC, then sequential -> 0.
    retire_with(1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc_hi", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    fetch(32'h0000_0013);
    retire_with(1'b0, 32'h0);
    chk("wrap_pc0", pc, 32'h0);
    chk("wrap_fault", {31'd0, fetch_fault}, 32'd0);
    chk("wrap_retire", retire_cnt, 32'd2);
    chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V 32I core. Holds the program counter, fetches instruction words from a variable-latency instruction memory over a request/acknowledge handshake, and presents a stable instruction to the decode and control logic. When the core signals completion of the current instruction, it computes the next PC from the branch decision (`PCSrc`) and the extended immediate produced downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory; held until acknowledged.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `instr`  out  32  registered instruction to decode (`op`=[6:0], `funct3`=[14:12], `funct7`=[31:25]).
- `instr_valid`  out  1  `instr` and `pc` describe a fetched, not-yet-retired instruction.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc`+4, combinational, mod 2^32.
- `instr_done`  in  1  core has finished executing `instr`; `PCSrc`/`imm_ext` valid this cycle.
- `PCSrc`  in  1  1 = take branch target, 0 = sequential.
- `imm_ext`  in  32  sign-extended branch offset.
- `fetch_fault`  out  1  sticky misaligned-target fault.
- `retire_cnt`  out  32  count of retired instructions.

## Operation
- States: BOOT, REQ, VALID, FAULT. Reset forces BOOT.
- Reset values: `pc`=RESET_PC, `instr`=32'h0000_0013 (NOP), `instr_valid`=0, `imem_req`=0, `fetch_fault`=0, `retire_cnt`=0.
- BOOT: `imem_req`=0; unconditionally to REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`: `instr`<=`imem_rdata`, go to VALID. Otherwise stay; request and address held stable.
- VALID: `instr_valid`=1, `imem_req`=0. On `instr_done`: next = `PCSrc` ? `pc`+`imm_ext` : `pc`+4 (32-bit add, carry discarded, wraps).
  - next[1:0]==0: `pc`<=next, `retire_cnt`+=1, go to REQ.
  - next[1:0]!=0: `pc` unchanged, `retire_cnt` unchanged, `fetch_fault`<=1, go to FAULT.
- FAULT: `imem_req`=0, `instr_valid`=0; all inputs ignored; exit only via `rst`.
- `instr_valid`, `imem_req` are decoded from state (no extra registers).
- `instr` holds its value outside the REQ-ack capture; `PCSrc`/`imm_ext` are sampled only on VALID & `instr_done`.

## Timing
- `imem_ack` may arrive in the first REQ cycle (zero wait) or any later cycle; no timeout.
- Best-case throughput: 2 cycles per instruction (REQ with immediate ack, VALID with immediate `instr_done`).
- `instr_valid` rises the cycle after the acknowledge edge and falls the cycle after the `instr_done` edge.
- `imem_ack` outside REQ (BOOT, VALID, FAULT): ignored; `instr` unchanged.
- `instr_done` outside VALID: ignored, no PC or counter change.
- `retire_cnt` wraps 32'hFFFF_FFFF -> 0.
- PC wrap: `pc`=32'hFFFF_FFFC, sequential -> 32'h0000_0000, legal, no fault.
- Reset mid-operation (including an outstanding request): `imem_req` drops asynchronously; an ack arriving during or after reset in BOOT is discarded; fetch restarts at RESET_PC.

## Test plan
- Reset release, `imem_ack` tied 1 at `imem_rdata`=32'h0050_0093: BOOT 1 cycle, REQ addr 0x0 1 cycle, then `instr`=32'h0050_0093, `instr_valid`=1, `pc`=0.
- Wait states: ack delayed 3 cycles -> `imem_req`=1, `imem_addr` stable for 4 cycles; `instr` captured only on ack cycle.
- Sequential + branch: `pc`=0x10, `instr_done`, `PCSrc`=0 -> next fetch 0x14; then `PCSrc`=1, `imm_ext`=32'hFFFF_FFF8 -> next fetch 0x0C; `retire_cnt`=2.
- Misaligned target: `pc`=0x20, `PCSrc`=1, `imm_ext`=0x6 -> `fetch_fault`=1, `pc` stays 0x20, `imem_req` stays 0 for 10 cycles despite `instr_done` pulses.
- Spurious inputs: `imem_ack` pulsed in VALID with new data and `instr_done` pulsed in REQ -> `instr`, `pc`, `retire_cnt` unchanged.
- Reset mid-REQ with ack in the same cycle -> all outputs return to reset values immediately; first post-reset request at RESET_PC; `retire_cnt`=0.
